// File: rtl/cache_cfg_pkg.sv
// Shared configuration for the pipelined cache address decoder: default geometry,
// width helpers and the decoded request record (misaligned field under CACHE_ALIGN_CHECK_EN).
package cache_cfg_pkg;

   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_NUM_LINES = 64;
   localparam int DEF_WAYS      = 2;
   localparam int DEF_OFFSET_W  = 2;

   function automatic int calcIndexW(input int numLines, input int ways);
      return $clog2(numLines / ways);
   endfunction

   function automatic int calcTagW(input int addrW, input int numLines, input int ways,
                                   input int offsetW);
      return addrW - calcIndexW(numLines, ways) - offsetW;
   endfunction

   localparam int DEF_INDEX_W = calcIndexW(DEF_NUM_LINES, DEF_WAYS);
   localparam int DEF_TAG_W   = calcTagW(DEF_ADDR_W, DEF_NUM_LINES, DEF_WAYS, DEF_OFFSET_W);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_e;

   // Field order here is the packing order used by every instance of the decoder.
   typedef struct packed {
      logic [DEF_TAG_W-1:0]    tag;
      logic [DEF_INDEX_W-1:0]  index;
      logic [DEF_OFFSET_W-1:0] offset;
      logic                    same_set;
`ifdef CACHE_ALIGN_CHECK_EN
      logic                    misaligned;
`endif
   } decoded_req_t;

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one skid slot,
// with a ready that depends only on the registered occupancy state.
module dec_skid_buf
   import cache_cfg_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   buf_state_e   state_q, state_d;
   logic [W-1:0] outData_q, outData_d;
   logic [W-1:0] skidData_q, skidData_d;
   logic         accept, xfer;

   assign in_ready  = !rst && (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = outData_q;
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   // Occupancy walks EMPTY/ONE/TWO; the skid slot only fills when the consumer stalls.
   always_comb begin
      state_d    = state_q;
      outData_d  = outData_q;
      skidData_d = skidData_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               outData_d = in_data;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (accept && xfer) begin
               outData_d = in_data;
            end else if (accept) begin
               skidData_d = in_data;
               state_d    = TWO;
            end else if (xfer) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (xfer) begin
               outData_d = skidData_q;
               state_d   = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         outData_q  <= '0;
         skidData_q <= '0;
      end else begin
         state_q    <= state_d;
         outData_q  <= outData_d;
         skidData_q <= skidData_d;
      end
   end

endmodule

// File: rtl/cache_addr_decode_pipe.sv
// Pipelined cache address decoder: tag/index/offset split with same-set detection behind
// a 2-entry skid buffer. Define CACHE_ALIGN_CHECK_EN to add the out_misaligned port.
module cache_addr_decode_pipe
   import cache_cfg_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int NUM_LINES = DEF_NUM_LINES,
   parameter int WAYS      = DEF_WAYS,
   parameter int OFFSET_W  = DEF_OFFSET_W,
   localparam int INDEX_W  = calcIndexW(NUM_LINES, WAYS),
   localparam int TAG_W    = calcTagW(ADDR_W, NUM_LINES, WAYS, OFFSET_W)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   in_addr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [TAG_W-1:0]    out_tag,
   output logic [INDEX_W-1:0]  out_index,
   output logic [OFFSET_W-1:0] out_offset,
`ifdef CACHE_ALIGN_CHECK_EN
   output logic                out_misaligned,
`endif
   output logic                out_same_set
);

   // Same layout as decoded_req_t, resized to this instance's geometry.
   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [INDEX_W-1:0]  index;
      logic [OFFSET_W-1:0] offset;
      logic                same_set;
`ifdef CACHE_ALIGN_CHECK_EN
      logic                misaligned;
`endif
   } req_t;

   req_t               reqIn, reqOut;
   logic [INDEX_W-1:0] prevIndex_q;
   logic               prevValid_q;
   logic               accept;

   assign accept = in_valid && in_ready;

   always_comb begin
      reqIn          = '0;
      reqIn.tag      = in_addr[ADDR_W-1:INDEX_W+OFFSET_W];
      reqIn.index    = in_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
      reqIn.offset   = in_addr[OFFSET_W-1:0];
      reqIn.same_set = prevValid_q && (in_addr[INDEX_W+OFFSET_W-1:OFFSET_W] == prevIndex_q);
`ifdef CACHE_ALIGN_CHECK_EN
      reqIn.misaligned = (in_addr[1:0] != 2'b00);
`endif
   end

   // The previous index tracks accepted requests only, so a stalled offer never counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         prevIndex_q <= '0;
         prevValid_q <= 1'b0;
      end else if (accept) begin
         prevIndex_q <= reqIn.index;
         prevValid_q <= 1'b1;
      end
   end

   dec_skid_buf #(
      .W($bits(req_t))
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (reqIn),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (reqOut)
   );

   assign out_tag      = reqOut.tag;
   assign out_index    = reqOut.index;
   assign out_offset   = reqOut.offset;
   assign out_same_set = reqOut.same_set;
`ifdef CACHE_ALIGN_CHECK_EN
   assign out_misaligned = reqOut.misaligned;
`endif

endmodule
